fp_add_seq: RTL and testbench

//  Multi-cycle sequencer for IEEE-754 add/subtract; drives exponent compare, operand swap/align, mantissa add, normalise, round.

---
 rtl/fp_pkg.sv | 41 ++++
 rtl/fp_add_seq_normalizer.sv | 24 ++
 rtl/fp_add_seq.sv | 289 ++++++++++++++++++++++++++++
 tb/tb_fp_add_seq.sv | 164 ++++++++++++++++
 4 files changed

// File: rtl/fp_pkg.sv
// Shared definitions for the sequential floating-point adder:
// default field widths, FSM state encoding, unpacked operand view,
// flag bit positions and the canonical quiet NaN.
package fp_pkg;

    localparam int FP_EXP_W = 8;
    localparam int FP_MAN_W = 23;
    localparam int FP_BIAS  = 2 ** (FP_EXP_W - 1) - 1;

    // Bit positions inside the 3-bit flags word {invalid, overflow, inexact}
    localparam int FLAG_INVALID  = 2;
    localparam int FLAG_OVERFLOW = 1;
    localparam int FLAG_INEXACT  = 0;

    localparam logic [31:0] FP_QNAN = 32'h7FC0_0000;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ALIGN,
        ST_ADD,
        ST_NORM,
        ST_ROUND,
        ST_DONE
    } fp_add_state_t;

    typedef struct packed {
        logic                sign;
        logic [FP_EXP_W-1:0] exp;
        logic [FP_MAN_W-1:0] man;
    } fp_unpacked_t;

    // Split a default-width word into its fields
    function automatic fp_unpacked_t fpUnpack(input logic [FP_EXP_W+FP_MAN_W:0] word);
        fp_unpacked_t u;
        u.sign = word[FP_EXP_W+FP_MAN_W];
        u.exp  = word[FP_EXP_W+FP_MAN_W-1:FP_MAN_W];
        u.man  = word[FP_MAN_W-1:0];
        return u;
    endfunction

endpackage

// File: rtl/fp_add_seq_normalizer.sv
// Combinational leading-zero counter plus left shift. The shifted output
// has its most significant set bit at the top; an all-zero input reports
// lzc = WIDTH and shifts out to zero.
module fp_normalizer #(
    parameter int WIDTH = 28,
    parameter int LZC_W = $clog2(WIDTH + 1)
) (
    input  logic [WIDTH-1:0] mantIn,
    output logic [WIDTH-1:0] mantOut,
    output logic [LZC_W-1:0] lzc
);

    // Highest set bit wins because it is visited last
    always_comb begin
        lzc = LZC_W'(WIDTH);
        for (int i = 0; i < WIDTH; i++) begin
            if (mantIn[i]) begin
                lzc = LZC_W'(WIDTH - 1 - i);
            end
        end
        mantOut = mantIn << lzc;
    end

endmodule

// File: rtl/fp_add_seq.sv
// Multi-cycle IEEE-754 add/subtract sequencer with valid/ready on both
// sides and one operation in flight. Fixed latency: accept at edge t,
// out_valid from edge t+5.
// Build option: define FP_ROUND_EN for round-to-nearest-even; otherwise
// the ROUND stage truncates (round toward zero) with unchanged latency.
module fp_add_seq
    import fp_pkg::*;
#(
    parameter int EXP_W = FP_EXP_W,
    parameter int MAN_W = FP_MAN_W
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [EXP_W+MAN_W:0]     a,
    input  logic [EXP_W+MAN_W:0]     b,
    input  logic                     sub,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [EXP_W+MAN_W:0]     result,
    output logic [2:0]               flags
);

    localparam int W     = 1 + EXP_W + MAN_W;
    localparam int MW    = MAN_W + 4;              // hidden + man + G + R + S
    localparam int LZC_W = $clog2(MAN_W + 6);
    localparam int XW    = EXP_W + 2;              // signed working exponent

    localparam logic [EXP_W:0]         SHIFT_LIMIT = (EXP_W+1)'(MAN_W + 3);
    localparam logic signed [XW-1:0]   ONE_X       = XW'(1);
    localparam logic signed [XW-1:0]   ZERO_X      = XW'(0);
    localparam logic signed [XW-1:0]   EXP_MAX_X   = XW'((2 ** EXP_W) - 1);
    localparam logic [W-1:0]           QNAN_W      = {1'b0, {EXP_W{1'b1}}, 1'b1, {(MAN_W-1){1'b0}}};

    fp_add_state_t stateReg, stateNext;

    logic [W-1:0]          aReg, bReg;
    logic                  subReg;

    logic                  signXReg, effSubReg;
    logic [EXP_W-1:0]      expXReg;
    logic [MW-1:0]         mantXReg, mantYReg;
    logic                  specialReg, specialInvalidReg;
    logic [W-1:0]          specialWordReg;

    logic [MW:0]           sumReg;

    logic [MW-1:0]         normMantReg;
    logic signed [XW-1:0]  normExpReg;
    logic                  normZeroReg, normSignReg;

    logic [W-1:0]          resultReg;
    logic [2:0]            flagsReg;
    logic                  outValidReg;

    // ---------------- operand decode (A and effective B) ----------------
    logic [W-1:0]          opWord [2];
    logic                  opSign [2];
    logic [EXP_W-1:0]      opExp  [2];
    logic [MAN_W-1:0]      opMan  [2];
    logic                  opNan  [2];
    logic                  opInf  [2];
    logic                  opZero [2];

    assign opWord[0] = aReg;
    assign opWord[1] = {bReg[W-1] ^ subReg, bReg[W-2:0]};

    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_decode
            assign opSign[gi] = opWord[gi][W-1];
            assign opExp[gi]  = opWord[gi][W-2:MAN_W];
            assign opMan[gi]  = opWord[gi][MAN_W-1:0];
            assign opNan[gi]  = (&opExp[gi]) & (|opMan[gi]);
            assign opInf[gi]  = (&opExp[gi]) & ~(|opMan[gi]);
            // Denormals are treated as signed zero
            assign opZero[gi] = (opExp[gi] == '0);
        end
    endgenerate

    // ---------------- ALIGN: swap so X has the larger magnitude ----------------
    logic [EXP_W:0]  expDiff, shiftAmt;
    logic            swap;
    logic [MW-1:0]   yFull, yShift, alignY;
    logic            yLost;
    logic            specialNext, specialInvalidNext;
    logic [W-1:0]    specialWordNext;

    // Exponent compare, operand swap and sticky-preserving right shift of Y
    always_comb begin
        expDiff  = {1'b0, opExp[0]} - {1'b0, opExp[1]};
        swap     = expDiff[EXP_W] | ((expDiff == '0) & (opMan[0] < opMan[1]));
        shiftAmt = swap ? (~expDiff + 1'b1) : expDiff;
        yFull    = swap ? {1'b1, opMan[0], 3'b000} : {1'b1, opMan[1], 3'b000};
        yShift   = yFull >> shiftAmt;
        yLost    = ((yShift << shiftAmt) != yFull);
        if (shiftAmt >= SHIFT_LIMIT) begin
            alignY = {{(MW-1){1'b0}}, |yFull};
        end else begin
            alignY = {yShift[MW-1:1], yShift[0] | yLost};
        end
    end

    // NaN / Inf / zero operands bypass the datapath with a fixed answer
    always_comb begin
        specialNext        = 1'b1;
        specialInvalidNext = 1'b0;
        specialWordNext    = '0;
        if (opNan[0] | opNan[1] | (opInf[0] & opInf[1] & (opSign[0] != opSign[1]))) begin
            specialWordNext    = QNAN_W;
            specialInvalidNext = 1'b1;
        end else if (opInf[0]) begin
            specialWordNext = opWord[0];
        end else if (opInf[1]) begin
            specialWordNext = opWord[1];
        end else if (opZero[0] & opZero[1]) begin
            specialWordNext = {opSign[0] & opSign[1], {(W-1){1'b0}}};
        end else if (opZero[0]) begin
            specialWordNext = opWord[1];
        end else if (opZero[1]) begin
            specialWordNext = opWord[0];
        end else begin
            specialNext = 1'b0;
        end
    end

    // ---------------- NORM ----------------
    logic [MW:0]           shiftedSum;
    logic [LZC_W-1:0]      lzc;
    logic [MW-1:0]         normMantNext;
    logic signed [XW-1:0]  normExpNext, expWide, lzcWide;
    logic                  normZeroNext, normSignNext;

    fp_normalizer #(
        .WIDTH (MW + 1),
        .LZC_W (LZC_W)
    ) u_normalizer (
        .mantIn  (sumReg),
        .mantOut (shiftedSum),
        .lzc     (lzc)
    );

    // Carry: shift right keeping sticky; otherwise shift left by the lzc
    always_comb begin
        expWide      = $signed({2'b00, expXReg});
        lzcWide      = $signed({{(XW-LZC_W){1'b0}}, lzc});
        normSignNext = signXReg;
        normZeroNext = 1'b0;
        if (sumReg[MW]) begin
            normMantNext = {sumReg[MW:2], sumReg[1] | sumReg[0]};
            normExpNext  = expWide + ONE_X;
        end else begin
            normMantNext = {shiftedSum[MW:2], shiftedSum[1] | shiftedSum[0]};
            normExpNext  = expWide + ONE_X - lzcWide;
        end
        if (sumReg == '0) begin
            normZeroNext = 1'b1;
            normSignNext = 1'b0;
        end else if (normExpNext <= ZERO_X) begin
            normZeroNext = 1'b1;
        end
    end

    // ---------------- ROUND ----------------
    logic [MAN_W:0]        frac;
    logic                  grsAny, roundInc;
    logic [MAN_W+1:0]      rounded;
    logic signed [XW-1:0]  roundExp;
    logic [MAN_W-1:0]      manField;
    logic [W-1:0]          resultNext;
    logic [2:0]            flagsNext;

    // Rounding, renormalisation on carry-out, overflow to infinity
    always_comb begin
        frac   = normMantReg[MW-1:3];
        grsAny = |normMantReg[2:0];
`ifdef FP_ROUND_EN
        roundInc = normMantReg[2] & (normMantReg[1] | normMantReg[0] | frac[0]);
`else
        roundInc = 1'b0;
`endif
        rounded  = {1'b0, frac} + {{(MAN_W+1){1'b0}}, roundInc};
        roundExp = normExpReg + (rounded[MAN_W+1] ? ONE_X : ZERO_X);
        manField = rounded[MAN_W+1] ? rounded[MAN_W:1] : rounded[MAN_W-1:0];
        flagsNext = '0;
        if (specialReg) begin
            resultNext                = specialWordReg;
            flagsNext[FLAG_INVALID]   = specialInvalidReg;
        end else if (normZeroReg) begin
            resultNext                = {normSignReg, {(W-1){1'b0}}};
            flagsNext[FLAG_INEXACT]   = grsAny;
        end else if (roundExp >= EXP_MAX_X) begin
            resultNext                = {normSignReg, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
            flagsNext[FLAG_OVERFLOW]  = 1'b1;
            flagsNext[FLAG_INEXACT]   = 1'b1;
        end else begin
            resultNext                = {normSignReg, roundExp[EXP_W-1:0], manField};
            flagsNext[FLAG_INEXACT]   = grsAny;
        end
    end

    // ---------------- FSM ----------------
    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            stateReg <= ST_IDLE;
        end else begin
            stateReg <= stateNext;
        end
    end

    // Next-state and ready decode
    always_comb begin
        stateNext = stateReg;
        in_ready  = 1'b0;
        case (stateReg)
            ST_IDLE: begin
                in_ready = 1'b1;
                if (in_valid) stateNext = ST_ALIGN;
            end
            ST_ALIGN: stateNext = ST_ADD;
            ST_ADD:   stateNext = ST_NORM;
            ST_NORM:  stateNext = ST_ROUND;
            ST_ROUND: stateNext = ST_DONE;
            ST_DONE: begin
                if (outValidReg && out_ready) stateNext = ST_IDLE;
            end
            default:  stateNext = ST_IDLE;
        endcase
    end

    // Per-stage datapath registers, loaded only in their own state
    always_ff @(posedge clk) begin
        case (stateReg)
            ST_IDLE: begin
                if (in_valid) begin
                    aReg   <= a;
                    bReg   <= b;
                    subReg <= sub;
                end
            end
            ST_ALIGN: begin
                signXReg          <= swap ? opSign[1] : opSign[0];
                expXReg           <= swap ? opExp[1]  : opExp[0];
                mantXReg          <= swap ? {1'b1, opMan[1], 3'b000} : {1'b1, opMan[0], 3'b000};
                mantYReg          <= alignY;
                effSubReg         <= opSign[0] ^ opSign[1];
                specialReg        <= specialNext;
                specialInvalidReg <= specialInvalidNext;
                specialWordReg    <= specialWordNext;
            end
            ST_ADD: begin
                sumReg <= effSubReg ? ({1'b0, mantXReg} - {1'b0, mantYReg})
                                    : ({1'b0, mantXReg} + {1'b0, mantYReg});
            end
            ST_NORM: begin
                normMantReg <= normMantNext;
                normExpReg  <= normExpNext;
                normZeroReg <= normZeroNext;
                normSignReg <= normSignNext;
            end
            default: ;
        endcase
    end

    // Output registers: result captured leaving ROUND, valid raised one cycle into DONE
    always_ff @(posedge clk) begin
        if (rst) begin
            resultReg   <= '0;
            flagsReg    <= '0;
            outValidReg <= 1'b0;
        end else begin
            if (stateReg == ST_ROUND) begin
                resultReg <= resultNext;
                flagsReg  <= flagsNext;
            end
            if (stateReg == ST_DONE && !outValidReg) begin
                outValidReg <= 1'b1;
            end else if (stateReg == ST_DONE && out_ready) begin
                outValidReg <= 1'b0;
            end
        end
    end

    assign out_valid = outValidReg;
    assign result    = resultReg;
    assign flags     = flagsReg;

endmodule

// File: tb/tb_fp_add_seq.sv
// Directed bench for fp_add_seq: hand-computed single-precision vectors,
// latency, back-pressure hold and mid-operation reset.
module tb_fp_add_seq;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] a, b;
    logic        sub;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] result;
    logic [2:0]  flags;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    fp_add_seq dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .sub       (sub),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .result    (result),
        .flags     (flags)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            failures++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, expv);
        end
    endtask

    // One full transaction: issue, measure latency, read, hand back
    task automatic runOp(input string tag, input logic [31:0] opA, input logic [31:0] opB,
                         input logic opSub, input logic [31:0] expRes, input logic [2:0] expFlags);
        int lat;
        bit seen;
        @(negedge clk);
        a = opA; b = opB; sub = opSub; in_valid = 1'b1;
        check({tag, "_in_ready"}, 32'(in_ready), 32'd1);
        @(posedge clk); #1;
        in_valid = 1'b0;
        lat = 0; seen = 1'b0;
        while (!seen && lat < 20) begin
            @(posedge clk); lat++; #1;
            if (out_valid) seen = 1'b1;
        end
        check({tag, "_latency"}, 32'(lat), 32'd5);
        @(negedge clk);
        check({tag, "_result"}, result, expRes);
        check({tag, "_flags"}, 32'(flags), 32'(expFlags));
        $display("OP %s a=%08h b=%08h sub=%0d -> result=%08h flags=%03b latency=%0d",
                 tag, opA, opB, opSub, result, flags, lat);
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        check({tag, "_out_valid_drop"}, 32'(out_valid), 32'd0);
        check({tag, "_in_ready_back"}, 32'(in_ready), 32'd1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int waitCnt;
        logic [31:0] heldResult;
        logic [2:0]  heldFlags;

        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; a = '0; b = '0; sub = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset_in_ready", 32'(in_ready), 32'd1);
        check("reset_out_valid", 32'(out_valid), 32'd0);
        check("reset_result", result, 32'h0);
        check("reset_flags", 32'(flags), 32'h0);
        rst = 1'b0;

        // Basic arithmetic
        runOp("one_plus_one",   32'h3F800000, 32'h3F800000, 1'b0, 32'h40000000, 3'b000);
        runOp("one_minus_one",  32'h3F800000, 32'h3F800000, 1'b1, 32'h00000000, 3'b000);
        runOp("three_minus_one",32'h40400000, 32'h3F800000, 1'b1, 32'h40000000, 3'b000);
        runOp("one_minus_two",  32'h3F800000, 32'h40000000, 1'b1, 32'hBF800000, 3'b000);
        runOp("x_plus_zero",    32'h3FC00000, 32'h00000000, 1'b0, 32'h3FC00000, 3'b000);

        // Specials and overflow
        runOp("inf_minus_inf",  32'h7F800000, 32'hFF800000, 1'b0, 32'h7FC00000, 3'b100);
        runOp("nan_in",         32'h7F800001, 32'h3F800000, 1'b0, 32'h7FC00000, 3'b100);
        runOp("inf_plus_one",   32'h7F800000, 32'h3F800000, 1'b0, 32'h7F800000, 3'b000);
        runOp("max_plus_max",   32'h7F7FFFFF, 32'h7F7FFFFF, 1'b0, 32'h7F800000, 3'b011);

        // Rounding: GR=11 rounds up under RNE, tie with even lsb stays
`ifdef FP_ROUND_EN
        runOp("round_up",       32'h3F800000, 32'h33C00000, 1'b0, 32'h3F800001, 3'b001);
`else
        runOp("round_up",       32'h3F800000, 32'h33C00000, 1'b0, 32'h3F800000, 3'b001);
`endif
        runOp("round_tie",      32'h3F800000, 32'h33800000, 1'b0, 32'h3F800000, 3'b001);

        // Back-pressure: hold DONE for 10 cycles while a stray op is offered
        @(negedge clk);
        a = 32'h3F800000; b = 32'h3F800000; sub = 1'b0; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        waitCnt = 0;
        while (!out_valid && waitCnt < 20) begin
            @(posedge clk); waitCnt++; #1;
        end
        check("hold_latency", 32'(waitCnt), 32'd5);
        heldResult = 32'h40000000;
        heldFlags  = 3'b000;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            a = 32'h40400000; b = 32'h3F800000; sub = 1'b1; in_valid = 1'b1;
            check("hold_result", result, heldResult);
            check("hold_flags", 32'(flags), 32'(heldFlags));
            check("hold_in_ready", 32'(in_ready), 32'd0);
            check("hold_out_valid", 32'(out_valid), 32'd1);
        end
        $display("OP hold result=%08h flags=%03b held 10 cycles", result, flags);
        @(negedge clk);
        in_valid = 1'b0; out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        check("hold_release_valid", 32'(out_valid), 32'd0);
        repeat (7) @(posedge clk);
        #1;
        check("hold_no_phantom_op", 32'(out_valid), 32'd0);
        runOp("after_hold",     32'h40400000, 32'h3F800000, 1'b1, 32'h40000000, 3'b000);

        // Reset while in ADD aborts the operation
        @(negedge clk);
        a = 32'h3F800000; b = 32'h3F800000; sub = 1'b0; in_valid = 1'b1;
        @(posedge clk); #1;            // accepted -> ALIGN
        in_valid = 1'b0;
        @(posedge clk); #1;            // ADD
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        check("abort_out_valid", 32'(out_valid), 32'd0);
        check("abort_in_ready", 32'(in_ready), 32'd1);
        repeat (7) @(posedge clk);
        #1;
        check("abort_no_output", 32'(out_valid), 32'd0);
        $display("OP abort reset in ADD, out_valid=%0d in_ready=%0d", out_valid, in_ready);
        runOp("after_abort",    32'h40400000, 32'h3F800000, 1'b0, 32'h40800000, 3'b000);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
